mips_muldiv: RTL

MIPS_MULDIV -- requirements
Module: mips_muldiv

---
 rtl/mips_pkg.sv | 18 +
 rtl/mips_muldiv.sv | 104 ++++++++++
 2 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared HI/LO unit operation codes and FSM state encoding.
package mips_pkg;

    typedef enum logic [1:0] {
        OP_MULT,
        OP_MULTU,
        OP_DIV,
        OP_DIVU
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIX
    } muldiv_state_t;

endpackage

// File: rtl/mips_muldiv.sv
// mips_muldiv: iterative MIPS multiply/divide unit with HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle on operand magnitudes.
module mips_muldiv
    import mips_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  muldiv_op_t       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    muldiv_state_t      state, state_nx;
    logic [2*WIDTH-1:0] acc, step, prod_fix, res;
    logic [WIDTH-1:0]   m, a_mag, b_mag, quo_fix, rem_fix;
    logic [WIDTH:0]     lhs, rhs, sum;
    logic [CNT_W-1:0]   cnt;
    logic               neg_q, neg_r, div_op, sgn, is_div_op, is_div, accept;

    assign busy      = state != IDLE;
    assign accept    = start && state == IDLE;
    assign sgn       = op == OP_MULT || op == OP_DIV;
    assign is_div_op = op == OP_DIV || op == OP_DIVU;
    assign a_mag     = (sgn && a[WIDTH-1]) ? -a : a;
    assign b_mag     = (sgn && b[WIDTH-1]) ? -b : b;
    assign is_div    = state == DIV;

    // Shared adder: upper half + multiplicand for MUL, partial remainder - divisor for DIV.
    assign lhs  = is_div ? {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} : {1'b0, acc[2*WIDTH-1:WIDTH]};
    assign rhs  = is_div ? ~{1'b0, m} : {1'b0, acc[0] ? m : {WIDTH{1'b0}}};
    assign sum  = lhs + rhs + {{WIDTH{1'b0}}, is_div};
    assign step = !is_div ? {sum, acc[WIDTH-1:1]} :
                  sum[WIDTH] ? {lhs[WIDTH-1:0], acc[WIDTH-2:0], 1'b0} :
                               {sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    // A zero divisor yields quotient all ones and remainder |a|; the sign fix restores a.
    assign prod_fix = neg_q ? -acc : acc;
    assign quo_fix  = div_by_zero ? {WIDTH{1'b1}} : neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    assign res      = div_op ? {rem_fix, quo_fix} : prod_fix;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? (is_div_op ? DIV : MUL) : IDLE;
            MUL,
            DIV:     state_nx = cnt == '0 ? FIX : state;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc         <= '0;
            m           <= '0;
            cnt         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            div_op      <= 1'b0;
            done        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                acc         <= {{WIDTH{1'b0}}, a_mag};
                m           <= b_mag;
                cnt         <= CNT_W'(WIDTH);
                neg_q       <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_r       <= sgn && a[WIDTH-1];
                div_op      <= is_div_op;
                div_by_zero <= is_div_op && b == '0;
            end else if (state == IDLE) begin
                if (hi_we) hi <= wdata;
                if (lo_we) lo <= wdata;
            end else if ((state == MUL || state == DIV) && cnt != '0) begin
                acc <= step;
                cnt <= cnt - 1'b1;
            end else if (state == FIX) begin
                {hi, lo} <= res;
                done     <= 1'b1;
            end
        end
    end

endmodule
